// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter sharing one mux_4_1 output path between four requesters.
// A single owner is registered; its index drives the mux selects and a one-hot
// grant. On release (or timeout pre-emption) the search pointer moves past the
// old owner, and the next requester is granted on the same edge with no idle
// bubble.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   req[3:0]  in   request per source, bit i requests mux input Ii
//   gnt[3:0]  out  registered one-hot grant, 0000 when no owner
//   gnt_valid out  registered, equals |gnt
//   sel_A     out  mux select MSB (owner[1])
//   sel_B     out  mux select LSB (owner[0])
//   owner[1:0]out  current or last owner index, equals {sel_A, sel_B}
//
// Parameters:
//   HOLD_MAX  maximum consecutive grant cycles per owner (2..255), timeout build only
//   CNT_W     hold counter width, 2**CNT_W > HOLD_MAX
//
// Build option: define GRANT_TIMEOUT_EN to pre-empt an owner after HOLD_MAX
// cycles when another source is waiting. Without it the hold counter is absent
// and an owner keeps the grant until it drops req.

module mux_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic       sel_A,
  output logic       sel_B,
  output logic [1:0] owner
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Reject illegal parameter combinations at elaboration.
  if ((HOLD_MAX < 2) || (HOLD_MAX > 255) || ((64'd1 << CNT_W) <= 64'(HOLD_MAX))) begin : g_bad_params
    $error("mux_rr_arbiter: illegal HOLD_MAX/CNT_W combination");
  end

  // First set bit of r, searching p, p+1, ... (mod 4). Returns p if r is empty.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = p + k[1:0];
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end else begin
        found   = found;
      end
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] gnt_q, gnt_d;
  logic       gnt_valid_q, gnt_valid_d;

  logic [3:0] others_s;
  logic       release_s;
  logic       rotate_s;
  logic [1:0] next_ptr_s;

`ifdef GRANT_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_MAX_C  = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST_C = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             preempt_s;
`endif

  // Rotation conditions shared by the next-state logic.
  always_comb begin
    others_s   = req & ~onehot(owner_q);
    release_s  = ~req[owner_q];
    next_ptr_s = owner_q + 2'd1;
`ifdef GRANT_TIMEOUT_EN
    // A lone requester is never pre-empted: another bit must be waiting.
    preempt_s  = (cnt_q == HOLD_LAST_C) && (|others_s);
    rotate_s   = release_s | preempt_s;
`else
    rotate_s   = release_s;
`endif
  end

  // Next-state, pointer, owner and grant computation.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
`ifdef GRANT_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = rr_pick(req, ptr_q);
          gnt_d   = onehot(rr_pick(req, ptr_q));
          state_d = BUSY;
`ifdef GRANT_TIMEOUT_EN
          cnt_d   = {CNT_W{1'b0}};
`endif
        end else begin
          // owner_d keeps the last owner so the mux selects stay put.
          gnt_d   = 4'b0000;
        end
      end
      BUSY: begin
        if (rotate_s) begin
          ptr_d = next_ptr_s;
          if (|others_s) begin
            // Hand over on the same edge: no idle bubble between owners.
            owner_d = rr_pick(others_s, next_ptr_s);
            gnt_d   = onehot(rr_pick(others_s, next_ptr_s));
`ifdef GRANT_TIMEOUT_EN
            cnt_d   = {CNT_W{1'b0}};
`endif
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end else begin
`ifdef GRANT_TIMEOUT_EN
          if (cnt_q >= HOLD_MAX_C) begin
            cnt_d = cnt_q;
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
`else
          gnt_d = gnt_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
    gnt_valid_d = |gnt_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      owner_q     <= 2'd0;
      gnt_q       <= 4'b0000;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

`ifdef GRANT_TIMEOUT_EN
  // Hold counter for timeout pre-emption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign owner     = owner_q;
  assign sel_A     = owner_q[1];
  assign sel_B     = owner_q[0];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter. A behavioural model computes the
// expected grant for each driven req value; the expectation is queued when the
// stimulus is applied and popped/compared after the following clock edge.
// Directed checks from constants cover reset, rotation, ties, idle hold,
// async reset and the timeout behaviour.

module tb_mux_rr_arbiter;

  localparam int HOLD_MAX = 4;
`ifdef GRANT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       sel_A;
  logic       sel_B;
  logic [1:0] owner;

  mux_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .sel_A     (sel_A),
    .sel_B     (sel_B),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct packed {
    logic [3:0] gnt;
    logic       vld;
    logic [1:0] own;
  } exp_t;

  exp_t exp_q[$];

  bit         m_busy;
  int         m_ptr;
  int         m_owner;
  logic [3:0] m_gnt;
  int         m_cnt;

  task automatic model_reset();
    m_busy  = 1'b0;
    m_ptr   = 0;
    m_owner = 0;
    m_gnt   = 4'b0000;
    m_cnt   = 0;
  endtask

  function automatic int find_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r);
    logic [3:0] others;
    int         w;
    if (!m_busy) begin
      w = find_from(r, m_ptr);
      if (w >= 0) begin
        m_busy  = 1'b1;
        m_owner = w;
        m_gnt   = 4'b0001 << w;
        m_cnt   = 0;
      end
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner] || (TO_EN && m_cnt == HOLD_MAX - 1 && others != 4'b0000)) begin
        m_ptr = (m_owner + 1) % 4;
        w = find_from(others, m_ptr);
        if (w >= 0) begin
          m_owner = w;
          m_gnt   = 4'b0001 << w;
          m_cnt   = 0;
        end else begin
          m_busy = 1'b0;
          m_gnt  = 4'b0000;
        end
      end else if (m_cnt < HOLD_MAX) begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  // Drive one req value, queue the model's prediction, compare after the edge.
  task automatic drive_cycle(input logic [3:0] r);
    exp_t e;
    req = r;
    model_step(r);
    e.gnt = m_gnt;
    e.vld = |m_gnt;
    e.own = m_owner[1:0];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("sb_gnt",   {4'b0, gnt},          {4'b0, e.gnt});
      check_eq("sb_valid", {7'b0, gnt_valid},    {7'b0, e.vld});
      check_eq("sb_owner", {6'b0, owner},        {6'b0, e.own});
      check_eq("sb_sel",   {6'b0, sel_A, sel_B}, {6'b0, e.own});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq(tag, {gnt, gnt_valid, sel_A, sel_B, 1'b0}, 8'h00);
    check_eq({tag, "_owner"}, {6'b0, owner}, 8'h00);
  endtask

  int first_own;
  int exp_own;

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    model_reset();

    // Reset held with all requests active
    #2;
    check_reset_outputs("rst_early");
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset_outputs("rst_hold");
    end
    #3 rst_n = 1'b1;
    drive_cycle(4'b1111);
    check_eq("first_gnt", {4'b0, gnt}, 8'h01);

    // Rotation: each owner holds 3 cycles then drops req for one cycle
    for (int k = 0; k < 4; k++) begin
      drive_cycle(4'b1111);
      drive_cycle(4'b1111);
      drive_cycle(4'b1111 & ~(4'b0001 << k));
      check_eq("rot_owner", {6'b0, sel_A, sel_B}, 8'((k + 1) % 4));
      check_eq("rot_nobubble", {7'b0, gnt_valid}, 8'd1);
    end

    // Tie after pointer move: I1 released -> ptr=2, then req=0011 -> I0
    drive_cycle(4'b0000);
    drive_cycle(4'b0010);
    check_eq("i1_gnt", {4'b0, gnt}, 8'h02);
    drive_cycle(4'b0000);
    drive_cycle(4'b0011);
    check_eq("wrap_tie", {4'b0, gnt}, 8'h01);

    // Idle hold of selects
    drive_cycle(4'b0000);
    drive_cycle(4'b0100);
    drive_cycle(4'b0000);
    check_eq("idle_gnt",   {4'b0, gnt}, 8'h00);
    check_eq("idle_valid", {7'b0, gnt_valid}, 8'h00);
    check_eq("idle_sel",   {6'b0, sel_A, sel_B}, 8'h02);
    check_eq("idle_owner", {6'b0, owner}, 8'h02);
    drive_cycle(4'b1000);
    check_eq("i3_gnt", {4'b0, gnt}, 8'h08);
    check_eq("i3_sel", {6'b0, sel_A, sel_B}, 8'h03);

    // Async reset between edges while I3 owns
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    req = 4'b0100;
    #2 rst_n = 1'b1;
    drive_cycle(4'b0100);
    check_eq("post_rst_gnt", {4'b0, gnt}, 8'h04);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      drive_cycle(4'($urandom_range(0, 15)));
    end

    // Two requesters held constantly
    drive_cycle(4'b0000);
    drive_cycle(4'b0000);
    drive_cycle(4'b0011);
    first_own = m_owner;
    for (int t = 1; t < 16; t++) begin
      drive_cycle(4'b0011);
      exp_own = (TO_EN && (((t / 4) % 2) == 1)) ? (first_own ^ 1) : first_own;
      check_eq("hold_owner", {6'b0, owner}, 8'(exp_own));
    end

    // Lone requester is never pre-empted
    drive_cycle(4'b0000);
    for (int t = 0; t < 25; t++) begin
      drive_cycle(4'b0001);
      check_eq("lone_gnt", {4'b0, gnt}, 8'h01);
    end

    // Simultaneous tie from ptr=0: req=1010 grants I1
    #2 rst_n = 1'b0;
    model_reset();
    #3 rst_n = 1'b1;
    drive_cycle(4'b1010);
    check_eq("tie_1010", {4'b0, gnt}, 8'h02);
    check_eq("tie_sel",  {6'b0, sel_A, sel_B}, 8'h01);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
